mux_pipe: RTL and testbench

Parametrised, pipelined N:1 selector with a valid/ready handshake on both sides. It generalises the fixed-size combinational case-statement muxes to any input count and data width. The 2:1 mux tree is cut into register stages so wide selectors meet timing. It sits between a request source that presents all candidate lanes plus a select index, and a downstream consumer that can apply backpressure.

---
 rtl/mux_pipe_pkg.sv | 19 +
 rtl/mux_pipe_stage.sv | 86 ++++++++
 rtl/mux_pipe.sv | 104 ++++++++++
 tb/tb_mux_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pipe_pkg.sv
// mux_pipe shared helpers: select width, pipeline depth, padded leaf count.
// Used by mux_pipe and mux_pipe_stage.
package mux_pipe_pkg;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int depth(input int n, input int levels);
    int d;
    d = (sel_w(n) + levels - 1) / levels;
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int leaves(input int n);
    return 1 << sel_w(n);
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: one register stage of the pipelined mux tree.
// Reduces 2^SI lanes by LVL 2:1 levels and registers valid/data/sel/err.
module mux_pipe_stage #(
  parameter int DATA_W = 1,
  parameter int SI     = 2,
  parameter int LVL    = 2,
  parameter bit ERR_EN = 1'b0,
  localparam int LI    = 1 << SI,
  localparam int LO    = LI >> LVL,
  localparam int SO    = (SI > LVL) ? SI - LVL : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_adv,
  input  logic                 i_valid,
  input  logic [LI*DATA_W-1:0] i_data,
  input  logic [SI-1:0]        i_sel,
  input  logic                 i_err,
  output logic                 o_valid,
  output logic [LO*DATA_W-1:0] o_data,
  output logic [SO-1:0]        o_sel,
  output logic                 o_err
);

  logic [DATA_W-1:0]   w_t [LVL+1][LI];
  logic [LO*DATA_W-1:0] w_nd;
  logic                 r_valid;
  logic [LO*DATA_W-1:0] r_data;

  always_comb begin
    for (int k = 0; k <= LVL; k++)
      for (int i = 0; i < LI; i++)
        w_t[k][i] = '0;
    for (int i = 0; i < LI; i++)
      w_t[0][i] = i_data[i*DATA_W +: DATA_W];
    for (int k = 0; k < LVL; k++)
      for (int i = 0; i < (LI >> (k + 1)); i++)
        w_t[k+1][i] = i_sel[k] ? w_t[k][2*i+1]
                               : w_t[k][2*i];
  end

  always_comb begin
    w_nd = '0;
    for (int i = 0; i < LO; i++)
      w_nd[i*DATA_W +: DATA_W] = w_t[LVL][i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      r_data  <= w_nd;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Remaining select bits ride along for the later stages.
  if (SI > LVL) begin : g_sel
    logic [SO-1:0] r_sel;
    always_ff @(posedge clk) begin
      if (!rst_n)     r_sel <= '0;
      else if (i_adv) r_sel <= i_sel[SI-1:LVL];
    end
    assign o_sel = r_sel;
  end else begin : g_nosel
    assign o_sel = '0;
  end

  if (ERR_EN) begin : g_err
    logic r_err;
    always_ff @(posedge clk) begin
      if (!rst_n)     r_err <= 1'b0;
      else if (i_adv) r_err <= i_err;
    end
    assign o_err = r_err;
  end else begin : g_noerr
    logic w_unused_err;
    assign w_unused_err = i_err;
    assign o_err = 1'b0;
  end

endmodule

// File: rtl/mux_pipe.sv
// mux_pipe: pipelined N:1 selector with valid/ready and global stall.
// Optional range check on in_sel via MUX_PIPE_RANGE_CHECK_EN.
module mux_pipe import mux_pipe_pkg::*; #(
  parameter int N_INPUTS     = 16,
  parameter int DATA_W       = 1,
  parameter int STAGE_LEVELS = 2,
  localparam int SEL_W       = sel_w(N_INPUTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_INPUTS*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_err,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int DEPTH  = depth(N_INPUTS, STAGE_LEVELS);
  localparam int LEAVES = leaves(N_INPUTS);

  logic                     w_adv;
  logic                     w_err;
  logic [LEAVES*DATA_W-1:0] w_pad;
  logic [LEAVES*DATA_W-1:0] w_d0;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  if (LEAVES > N_INPUTS) begin : g_pad
    assign w_pad = {{((LEAVES - N_INPUTS) * DATA_W){1'b0}}, in_data};
  end else begin : g_nopad
    assign w_pad = in_data;
  end

`ifdef MUX_PIPE_RANGE_CHECK_EN
  localparam bit ERR_EN = 1'b1;
  localparam logic [SEL_W:0] NLIM = (SEL_W + 1)'(N_INPUTS);
  assign w_err = ({1'b0, in_sel} >= NLIM);
`else
  localparam bit ERR_EN = 1'b0;
  assign w_err = 1'b0;
`endif

  assign w_d0 = w_err ? '0 : w_pad;

  for (genvar j = 0; j < DEPTH; j++) begin : g_st
    localparam int SI = SEL_W - j * STAGE_LEVELS;
    localparam int LV = (SI < STAGE_LEVELS) ? SI : STAGE_LEVELS;
    localparam int LI = 1 << SI;
    localparam int LO = LI >> LV;
    localparam int SO = (SI > LV) ? SI - LV : 1;

    logic                 w_iv;
    logic [LI*DATA_W-1:0] w_id;
    logic [SI-1:0]        w_is;
    logic                 w_ie;
    logic                 w_ov;
    logic [LO*DATA_W-1:0] w_od;
    logic [SO-1:0]        w_os;
    logic                 w_oe;

    if (j == 0) begin : g_src
      assign w_iv = in_valid;
      assign w_id = w_d0;
      assign w_is = in_sel;
      assign w_ie = w_err;
    end else begin : g_link
      assign w_iv = g_st[j-1].w_ov;
      assign w_id = g_st[j-1].w_od;
      assign w_is = g_st[j-1].w_os;
      assign w_ie = g_st[j-1].w_oe;
    end

    mux_pipe_stage #(
      .DATA_W (DATA_W),
      .SI     (SI),
      .LVL    (LV),
      .ERR_EN (ERR_EN)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv),
      .i_valid (w_iv),
      .i_data  (w_id),
      .i_sel   (w_is),
      .i_err   (w_ie),
      .o_valid (w_ov),
      .o_data  (w_od),
      .o_sel   (w_os),
      .o_err   (w_oe)
    );
  end

  assign out_valid = g_st[DEPTH-1].w_ov;
  assign out_data  = g_st[DEPTH-1].w_od;
  assign out_err   = g_st[DEPTH-1].w_oe;

  logic w_unused;
  assign w_unused = ^g_st[DEPTH-1].w_os;

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: scoreboard bench for mux_pipe (N=40, W=8, 3 stages).
// Reference model picks lanes by index; monitor pops on out transfer.
module tb_mux_pipe;

  localparam int N  = 40;
  localparam int W  = 8;
  localparam int SW = 6;
  localparam int DEPTH = 3;
`ifdef MUX_PIPE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [SW-1:0]  in_sel = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_err;
  logic           out_valid;
  logic           out_ready = 1'b0;

  mux_pipe #(
    .N_INPUTS     (N),
    .DATA_W       (W),
    .STAGE_LEVELS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
    int           edge_n;
    bit           lat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int n_in = 0;
  int n_out = 0;
  int cyc = 0;
  bit lat_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_d;
  logic prev_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [SW-1:0] s,
                                 input logic [N*W-1:0] d);
    exp_t x;
    int si;
    si = int'(s);
    x.d = (si < N) ? d[si*W +: W] : '0;
    x.e = RC && (si >= N);
    x.edge_n = 0;
    x.lat = 1'b0;
    return x;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      n_in -= q.size();
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(prev_d));
        chk("hold_err", 64'(out_err), 64'(prev_e));
      end
      if (in_valid && in_ready) begin
        exp_t x;
        x = model(in_sel, in_data);
        x.edge_n = cyc + 1;
        x.lat = lat_mode;
        q.push_back(x);
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("spurious_beat", 64'(out_data), 64'hdead);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("out_data", 64'(out_data), 64'(x.d));
          chk("out_err", 64'(out_err), 64'(x.e));
          if (x.lat)
            chk("latency", 64'(cyc + 1 - x.edge_n), 64'(DEPTH));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_e = out_err;
    end
  end

  task automatic send(input logic [SW-1:0] s, input logic [N*W-1:0] d);
    bit ok;
    ok = 1'b0;
    in_sel = s;
    in_data = d;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] rnd_lanes();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  logic [N*W-1:0] lanes;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Full-rate sweep over all 64 leaves, including padded ones.
    for (int i = 0; i < N; i++) lanes[i*W +: W] = W'(i * 7 + 3);
    lat_mode = 1'b1;
    out_ready = 1'b1;
    for (int s = 0; s < 64; s++) send(SW'(s), lanes);
    drain();

    // Bubbles: alternate valid beats.
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      in_sel = SW'($urandom_range(0, N - 1));
      in_data = rnd_lanes();
      @(posedge clk);
      #1;
    end
    drain();
    lat_mode = 1'b0;

    // Backpressure: out_ready low 3 cycles after first out_valid.
    lanes = rnd_lanes();
    lanes[0*W +: W] = 8'h11;
    lanes[1*W +: W] = 8'h22;
    lanes[2*W +: W] = 8'h33;
    lanes[3*W +: W] = 8'h44;
    out_ready = 1'b0;
    fork
      begin
        send(SW'(3), lanes);
        send(SW'(2), lanes);
        send(SW'(1), lanes);
        send(SW'(0), lanes);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom % 10) < 7;
      in_sel = ($urandom % 8 == 0) ? SW'($urandom_range(N, 63))
                                   : SW'($urandom_range(0, N - 1));
      in_data = rnd_lanes();
      out_ready = ($urandom % 10) < 6;
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sel = SW'($urandom_range(0, N - 1));
      in_data = rnd_lanes();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_err", 64'(out_err), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("beats_in_eq_out", 64'(n_out), 64'(n_in));
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
